demux1x9_buf: RTL and testbench
===============================

Name: demux1x9_buf

Overview:
- 1-to-9 registered distributor: the write-side counterpart of the 9:1 datapath select.
- Steers one 32-bit source word to one of nine single-entry holding slots, chosen by a 4-bit select.
- Each slot presents its word with valid/ack handshaking to its own consumer.
- Sits between a shared result bus (ALU/memory write-back) and nine independent destination stages.

Parameters:
- DATA_W, 32, width of each data word.
- SEL_W, 4, width of the select field.
- NUM_SLOTS, 9, number of destination slots (fixed; select decode depends on it).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  source word.
- sel  input  SEL_W  destination slot index.
- in_valid  input  1  source offers in_data/sel this cycle.
- in_ready  output  1  combinational; destination slot can accept this cycle.
- out_data  output  NUM_SLOTS*DATA_W  flattened slot contents; slot i at bits [i*DATA_W +: DATA_W].
- out_valid  output  NUM_SLOTS  per-slot holds-word flag.
- out_ack  input  NUM_SLOTS  per-slot consumer pop.
- occ  output  4  registered count of slots with out_valid=1 (0..9).
- drop_cnt  output  8  registered count of cycles with in_valid=1 and in_ready=0, saturating at 255.

Behaviour:
- Reset (clk edge with reset=1): all out_data=0, out_valid=0, occ=0, drop_cnt=0. Reset overrides every concurrent write, ack and count.
- Destination decode: dest = sel for sel 0..7. dest = 8 for sel 8..15 (default slot, matches the 9:1 mux default leg).
- in_ready = ~out_valid[dest] | out_ack[dest]. Combinational from sel, out_valid and out_ack; no dependency on in_valid.
- Accept = in_valid & in_ready. On accept:
  - slot[dest].data <= in_data.
  - out_valid[dest] <= 1.
  - Latency: data is visible on out_data one cycle after the accept edge.
- Ack: out_ack[i] & out_valid[i] clears out_valid[i] at the next edge. Data is retained (not zeroed).
  - Ack on an empty slot is ignored.
  - Multiple slots may be acked in the same cycle.
- Simultaneous accept and ack on the same slot: the old word is consumed and the new word is written. out_valid stays 1; occ is unchanged.
- Simultaneous accept on slot A and ack on a different slot B: both take effect. Net occ change is 0.
- occ_next = occ + accept_into_empty − number of valid acks, where an ack on the dest slot coincident with an accept is not counted. occ never exceeds 9 and never goes below 0.
- Stall: in_valid & ~in_ready leaves all slots unchanged. drop_cnt increments per stalled cycle and saturates at 8'hFF. The source must hold in_data/sel stable until accepted; the block does not enforce this.
- No combinational path from in_data to out_data; all outputs except in_ready are registered.
- Reset asserted mid-stall or mid-ack: the next cycle shows all slots empty and in_ready=1 for any sel.

Decomposition:
- Shared package demux_pkg:
  - DATA_W=32, SEL_W=4, NUM_SLOTS=9.
  - DEFAULT_SLOT=4'd8.
  - A function sel_to_dest(sel) returning the clamped index.
- Sub-module demux_slot: one single-entry holding register.
  - Inputs: clk, reset, wr_en, wr_data, ack.
  - Outputs: data, valid.
  - Instantiated NUM_SLOTS times via generate.
- Top level holds: decode, in_ready, occ and drop_cnt.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=9'h000, occ=0, drop_cnt=0, in_ready=1 for every sel 0..15.
- Fill each slot: in_valid=1, sel=0..8 with in_data=32'hA000_0000+sel, one per cycle -> after 9 cycles out_valid=9'h1FF, occ=9, slot 5 reads 32'hA000_0005.
- Default leg: with slot 8 empty, sel=4'd13, in_data=32'hDEAD_BEEF -> slot 8 = 32'hDEADBEEF, out_valid[8]=1, slots 0..7 unchanged. A repeat with sel=4'd15 and no ack -> in_ready=0, drop_cnt increments by 1 per cycle.
- Replace-on-ack: slot 3 holds 32'h1111_1111; same cycle out_ack[3]=1, sel=3, in_data=32'h2222_2222 -> in_ready=1, next cycle slot 3 = 32'h22222222, out_valid[3]=1, occ unchanged.
- Multi-ack plus stray ack: slots 0,2,4 full (occ=3); out_ack=9'b0_0001_0111 -> next cycle out_valid[0,2,4]=0, occ=0, slot 1 stays empty, stored data unchanged.
- Saturation and reset mid-operation: hold in_valid=1 on a full slot for 300 cycles -> drop_cnt=255. Then pulse reset=1 one cycle with out_ack[3]=1 and in_valid=1 -> next cycle every output returns to its reset value and no write is observed.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-9 registered distributor.
// The select decode and the occupancy bit count are kept here.
package demux_pkg;

  localparam int DATA_W    = 32;
  localparam int SEL_W     = 4;
  localparam int NUM_SLOTS = 9;

  localparam logic [SEL_W-1:0] DEFAULT_SLOT = 4'd8;

  // Selects 8..15 all land on the default slot, mirroring the 9:1 mux default leg.
  function automatic logic [SEL_W-1:0] sel_to_dest(input logic [SEL_W-1:0] sel);
    return (sel > DEFAULT_SLOT) ? DEFAULT_SLOT : sel;
  endfunction

  function automatic logic [3:0] count_ones(input logic [NUM_SLOTS-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding register with valid/ack handshake.
// A write in the same cycle as an ack wins: the old word is consumed, the new one stays valid.
module demux_slot
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ack,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d  = wr_data;
      valid_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/demux1x9_buf.sv
// 1-to-9 registered distributor: steers one source word into one of nine
// single-entry slots, tracks occupancy and counts stalled offers.
module demux1x9_buf
  import demux_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NUM_SLOTS*DATA_W-1:0] out_data,
  output logic [NUM_SLOTS-1:0]        out_valid,
  input  logic [NUM_SLOTS-1:0]        out_ack,
  output logic [3:0]                  occ,
  output logic [7:0]                  drop_cnt
);

  logic [SEL_W-1:0]     dest;
  logic                 accept;
  logic                 acc_empty;
  logic [NUM_SLOTS-1:0] wr_en_vec;
  logic [NUM_SLOTS-1:0] ack_eff;
  logic [3:0]           occ_q, occ_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  always_comb begin
    dest      = sel_to_dest(sel);
    in_ready  = ~out_valid[dest] | out_ack[dest];
    accept    = in_valid & in_ready;
    acc_empty = accept & ~out_valid[dest];
    wr_en_vec = '0;
    if (accept) begin
      wr_en_vec[dest] = 1'b1;
    end
    // An ack on the slot being rewritten is a replacement, not a departure.
    ack_eff = out_ack & out_valid & ~wr_en_vec;
    occ_d   = occ_q + {3'b000, acc_empty} - count_ones(ack_eff);

    drop_cnt_d = drop_cnt_q;
    if (in_valid && !in_ready && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= 4'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      occ_q      <= occ_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      demux_slot u_slot (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_vec[gi]),
        .wr_data (in_data),
        .ack     (out_ack[gi]),
        .data    (out_data[gi*DATA_W +: DATA_W]),
        .valid   (out_valid[gi])
      );
    end
  endgenerate

  assign occ      = occ_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux1x9_buf.sv
// Self-checking bench for demux1x9_buf: a behavioural slot model predicts every
// output each cycle, and accepted writes go through a scoreboard queue.
module tb_demux1x9_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic [3:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [287:0] out_data;
  logic [8:0]   out_valid;
  logic [8:0]   out_ack;
  logic [3:0]   occ;
  logic [7:0]   drop_cnt;

  demux1x9_buf dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occ       (occ),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] exp_data[9];
  logic [8:0]  exp_valid;
  int          exp_drop;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int count_valid(input logic [8:0] v);
    int c = 0;
    for (int i = 0; i < 9; i++) c += int'(v[i]);
    return c;
  endfunction

  // One clock of stimulus: check in_ready, advance the model, then check all registered outputs.
  task automatic step(input logic rst, input logic iv, input logic [3:0] s,
                      input logic [31:0] d, input logic [8:0] ack);
    int          dest;
    logic        rdy;
    logic        acc;
    logic [8:0]  nv;
    logic [287:0] flat;
    sb_t         e;
    reset = rst; in_valid = iv; sel = s; in_data = d; out_ack = ack;
    #1;
    dest = (s >= 4'd8) ? 8 : int'(s);
    rdy  = !exp_valid[dest] || ack[dest];
    check_eq("in_ready", {287'd0, in_ready}, {287'd0, rdy});
    acc = iv && rdy && !rst;
    if (rst) begin
      for (int i = 0; i < 9; i++) exp_data[i] = '0;
      exp_valid = '0;
      exp_drop  = 0;
      sb_q.delete();
    end else begin
      nv = exp_valid;
      for (int i = 0; i < 9; i++) begin
        if (acc && i == dest) begin
          nv[i]       = 1'b1;
          exp_data[i] = d;
        end else if (ack[i]) begin
          nv[i] = 1'b0;
        end
      end
      exp_valid = nv;
      if (iv && !rdy && exp_drop < 255) exp_drop++;
      if (acc) sb_q.push_back('{dest, d});
    end
    @(posedge clk);
    #1;
    flat = '0;
    for (int i = 0; i < 9; i++) flat[i*32 +: 32] = exp_data[i];
    check_eq("out_valid", {279'd0, out_valid}, {279'd0, exp_valid});
    check_eq("occ", {284'd0, occ}, 288'(count_valid(exp_valid)));
    check_eq("drop_cnt", {280'd0, drop_cnt}, 288'(exp_drop));
    check_eq("out_data", out_data, flat);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("write slot %0d data %h -> out %h valid %b", e.slot, e.data,
               out_data[e.slot*32 +: 32], out_valid[e.slot]);
      check_eq("sb_data", {256'd0, out_data[e.slot*32 +: 32]}, {256'd0, e.data});
      check_eq("sb_valid", {287'd0, out_valid[e.slot]}, 288'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) exp_data[i] = '0;
    exp_valid = '0;
    exp_drop  = 0;

    // Reset then idle sweep of every select value.
    step(1'b1, 1'b0, 4'd0, 32'd0, 9'd0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 9'd0);
    for (int s = 0; s < 16; s++) step(1'b0, 1'b0, 4'(s), 32'd0, 9'd0);

    // Fill every slot.
    for (int s = 0; s < 9; s++) step(1'b0, 1'b1, 4'(s), 32'hA000_0000 + s, 9'd0);
    check_eq("fill_valid", {279'd0, out_valid}, {279'd0, 9'h1FF});
    check_eq("fill_occ", {284'd0, occ}, 288'd9);
    check_eq("fill_slot5", {256'd0, out_data[5*32 +: 32]}, {256'd0, 32'hA000_0005});

    // Default leg: empty slot 8, write via sel 13, then stall on sel 15.
    step(1'b0, 1'b0, 4'd0, 32'd0, 9'h100);
    step(1'b0, 1'b1, 4'd13, 32'hDEAD_BEEF, 9'd0);
    check_eq("dflt_slot8", {256'd0, out_data[8*32 +: 32]}, {256'd0, 32'hDEAD_BEEF});
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'd15, 32'h5555_5555, 9'd0);
    check_eq("dflt_drop", {280'd0, drop_cnt}, 288'd3);

    // Replace-on-ack on slot 3.
    step(1'b0, 1'b0, 4'd0, 32'd0, 9'h008);
    step(1'b0, 1'b1, 4'd3, 32'h1111_1111, 9'd0);
    step(1'b0, 1'b1, 4'd3, 32'h2222_2222, 9'h008);
    check_eq("repl_slot3", {256'd0, out_data[3*32 +: 32]}, {256'd0, 32'h2222_2222});
    check_eq("repl_occ", {284'd0, occ}, 288'd9);

    // Multi-ack with a stray ack on an empty slot.
    step(1'b0, 1'b0, 4'd0, 32'd0, 9'h1FF);
    step(1'b0, 1'b1, 4'd0, 32'hC000_0000, 9'd0);
    step(1'b0, 1'b1, 4'd2, 32'hC000_0002, 9'd0);
    step(1'b0, 1'b1, 4'd4, 32'hC000_0004, 9'd0);
    check_eq("multi_occ3", {284'd0, occ}, 288'd3);
    step(1'b0, 1'b0, 4'd0, 32'd0, 9'b0_0001_0111);
    check_eq("multi_occ0", {284'd0, occ}, 288'd0);
    check_eq("multi_keep2", {256'd0, out_data[2*32 +: 32]}, {256'd0, 32'hC000_0002});

    // Saturation, then reset in the middle of a stall and an ack.
    step(1'b0, 1'b1, 4'd3, 32'h3333_3333, 9'd0);
    for (int k = 0; k < 300; k++) step(1'b0, 1'b1, 4'd3, 32'h4444_4444, 9'd0);
    check_eq("sat_drop", {280'd0, drop_cnt}, 288'd255);
    step(1'b1, 1'b1, 4'd3, 32'h7777_7777, 9'h008);
    check_eq("rst_valid", {279'd0, out_valid}, 288'd0);
    check_eq("rst_data", out_data, 288'd0);
    for (int s = 0; s < 16; s++) step(1'b0, 1'b0, 4'(s), 32'd0, 9'd0);

    // Random traffic against the model.
    for (int k = 0; k < 200; k++) begin
      logic [8:0] a;
      a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'd0;
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
